keypad_scan_controller: RTL and testbench
=========================================

KEYPAD_SCAN_CONTROLLER -- requirements
Module: keypad_scan_controller

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 500000, clk cycles per scan tick (>=2).
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 3, consecutive identical tick samples needed to accept a press or release (>=1).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on posedge clk.
REQ-004 SHALL have port initialize  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports col1, col2, col3  input  1 each  asynchronous keypad column lines, high = key closed on the driven row.
REQ-006 SHALL have port scan_en  input  1  high = scanning allowed; low = tick counter and row pointer frozen.
REQ-007 SHALL have ports row1, row2, row3, row4  output  1 each  registered row drive, exactly one high at all times.
REQ-008 SHALL have port key_code  output  4  code of last accepted key.
REQ-009 SHALL have port key_valid  output  1  one-cycle pulse on acceptance of a press.
REQ-010 SHALL have port key_held  output  1  high from acceptance until release is accepted.
REQ-011 SHALL have port scan_state  output  2  current FSM state: SCAN=0, DEBOUNCE=1, PRESSED=2, RELEASE=3.

Function
REQ-012 SHALL pass col1..col3 through a 2-flop synchronizer; all column decisions use synchronized values only.
REQ-013 SHALL run a tick counter 0..SCAN_DIV-1 while scan_en=1; tick asserts for one cycle at terminal count, then counter wraps to 0.
REQ-014 SHALL evaluate FSM transitions only on tick cycles; non-tick cycles hold state, row drive and debounce count.
REQ-015 SCAN: on tick, synchronized cols all zero -> advance row one-hot row1->row2->row3->row4->row1; exactly one col high -> latch pattern, debounce count=1, go DEBOUNCE, row frozen; two or more cols high -> no latch, advance row.
REQ-016 DEBOUNCE: on tick, cols equal latched pattern -> count+1; count reaching DEBOUNCE_SCANS -> go PRESSED.
REQ-017 DEBOUNCE: different single-col pattern -> relatch, count=1; zero or multiple cols -> return to SCAN and advance row.
REQ-018 On DEBOUNCE->PRESSED, key_code SHALL load the encoded key and key_valid SHALL pulse high for exactly the following cycle.
REQ-019 Encoding: row1 col1/2/3 = 1/2/3; row2 = 4/5/6; row3 = 7/8/9; row4 col1 = 4'hA (star), col2 = 0, col3 = 4'hB (sharp).
REQ-020 PRESSED: row frozen, key_held=1; any nonzero col tick -> stay; all-zero tick -> count=1, go RELEASE.
REQ-021 RELEASE: all-zero tick -> count+1, at DEBOUNCE_SCANS -> key_held=0, advance row, go SCAN; nonzero tick -> back to PRESSED, no new key_valid.
REQ-022 key_code SHALL hold its value until the next accepted press; it SHALL not change in SCAN/DEBOUNCE/RELEASE.
REQ-023 With DEBOUNCE_SCANS=1, SCAN SHALL still pass through DEBOUNCE for one tick before PRESSED.
REQ-024 scan_en low SHALL freeze tick counter, state, row and count; key_valid SHALL not assert; outputs hold.
REQ-025 At most one key_valid pulse per physical press, regardless of hold duration.

Reset
REQ-026 initialize=1 at posedge clk SHALL set: row1=1, row2..row4=0, key_code=0, key_valid=0, key_held=0, scan_state=SCAN, tick counter=0, debounce count=0, synchronizer flops=0.
REQ-027 Reset SHALL win over every other event in the same cycle, including a tick or a pending key_valid; a press in progress is discarded.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2)
REQ-028 Reset: initialize high 2 cycles -> row1..4=1000, key_code=0, key_valid=0, key_held=0, scan_state=0; with cols idle row rotates every 4 cycles.
REQ-029 Press '5': col2 high while row2 driven, held 40 cycles -> one key_valid pulse, key_code=5, key_held=1, row2 frozen; no further pulse.
REQ-030 Release '5': cols low -> key_held=0 after 2 zero ticks, row advances to row3, key_code stays 5.
REQ-031 Bounce: col1 toggling each tick on row4 -> no key_valid; steady col3 on row4 -> key_code=4'hB, single pulse.
REQ-032 Multi-column: col1 and col3 high together -> never leaves SCAN, no key_valid, rows keep rotating.
REQ-033 Reset mid-press: initialize in PRESSED or on the DEBOUNCE->PRESSED tick -> no key_valid, all REQ-026 values next cycle.

Source files
------------

// File: rtl/keypad_scan_controller.sv
// 4x3 matrix keypad scanner: rotates a one-hot row drive on a divided scan tick,
// debounces single-column presses and releases, and reports the encoded key.
module keypad_scan_controller #(
  parameter int SCAN_DIV       = 500000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       initialize,
  input  logic       col1,
  input  logic       col2,
  input  logic       col3,
  input  logic       scan_en,
  output logic       row1,
  output logic       row2,
  output logic       row3,
  output logic       row4,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] scan_state
);

  localparam int CNW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW  = $clog2(DEBOUNCE_SCANS + 2);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t          state_r, state_n;
  logic [2:0]      col_meta_r, col_sync_r;
  logic [CNW-1:0]  cnt_r;
  logic [3:0]      row_r, row_n, row_rot_s;
  logic [DW-1:0]   dcnt_r, dcnt_n, dcnt_inc_s;
  logic [2:0]      pat_r, pat_n;
  logic [3:0]      key_code_r, key_code_n;
  logic            key_valid_r, key_valid_n;
  logic            key_held_r, key_held_n;
  logic            tick_s, zero_s, single_s;

  // Row 1..3 map to 1..9; row 4 carries star, zero and sharp.
  function automatic logic [3:0] encode_key(input logic [3:0] row, input logic [2:0] col);
    logic [1:0] cidx;
    logic [3:0] code;
    case (col)
      3'b001:  cidx = 2'd0;
      3'b010:  cidx = 2'd1;
      3'b100:  cidx = 2'd2;
      default: cidx = 2'd0;
    endcase
    case (row)
      4'b0001: code = 4'd1 + {2'b00, cidx};
      4'b0010: code = 4'd4 + {2'b00, cidx};
      4'b0100: code = 4'd7 + {2'b00, cidx};
      4'b1000: code = (cidx == 2'd0) ? 4'hA : ((cidx == 2'd1) ? 4'h0 : 4'hB);
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  assign tick_s     = scan_en && (cnt_r == CNW'(SCAN_DIV - 1));
  assign zero_s     = (col_sync_r == 3'b000);
  assign single_s   = (col_sync_r == 3'b001) || (col_sync_r == 3'b010) || (col_sync_r == 3'b100);
  assign row_rot_s  = {row_r[2:0], row_r[3]};
  assign dcnt_inc_s = dcnt_r + DW'(1);

  // Column synchronizer and scan tick divider.
  always_ff @(posedge clk) begin
    if (initialize) begin
      col_meta_r <= 3'b000;
      col_sync_r <= 3'b000;
      cnt_r      <= {CNW{1'b0}};
    end else begin
      col_meta_r <= {col3, col2, col1};
      col_sync_r <= col_meta_r;
      if (tick_s) begin
        cnt_r <= {CNW{1'b0}};
      end else if (scan_en) begin
        cnt_r <= cnt_r + CNW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Scan FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (initialize) begin
      state_r     <= SCAN;
      row_r       <= 4'b0001;
      dcnt_r      <= {DW{1'b0}};
      pat_r       <= 3'b000;
      key_code_r  <= 4'h0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      state_r     <= state_n;
      row_r       <= row_n;
      dcnt_r      <= dcnt_n;
      pat_r       <= pat_n;
      key_code_r  <= key_code_n;
      key_valid_r <= key_valid_n;
      key_held_r  <= key_held_n;
    end
  end

  // Next-state logic; everything holds between ticks.
  always_comb begin
    state_n     = state_r;
    row_n       = row_r;
    dcnt_n      = dcnt_r;
    pat_n       = pat_r;
    key_code_n  = key_code_r;
    key_valid_n = 1'b0;
    key_held_n  = key_held_r;
    if (tick_s) begin
      case (state_r)
        SCAN: begin
          if (single_s) begin
            pat_n   = col_sync_r;
            dcnt_n  = DW'(1);
            state_n = DEBOUNCE;
          end else begin
            row_n = row_rot_s;
          end
        end
        DEBOUNCE: begin
          if (col_sync_r == pat_r) begin
            dcnt_n = dcnt_inc_s;
            if (dcnt_inc_s >= DW'(DEBOUNCE_SCANS)) begin
              state_n     = PRESSED;
              key_code_n  = encode_key(row_r, pat_r);
              key_valid_n = 1'b1;
              key_held_n  = 1'b1;
            end else begin
              state_n = DEBOUNCE;
            end
          end else if (single_s) begin
            pat_n  = col_sync_r;
            dcnt_n = DW'(1);
          end else begin
            state_n = SCAN;
            dcnt_n  = {DW{1'b0}};
            row_n   = row_rot_s;
          end
        end
        PRESSED: begin
          if (zero_s) begin
            dcnt_n  = DW'(1);
            state_n = RELEASE;
          end else begin
            state_n = PRESSED;
          end
        end
        RELEASE: begin
          if (zero_s) begin
            dcnt_n = dcnt_inc_s;
            if (dcnt_inc_s >= DW'(DEBOUNCE_SCANS)) begin
              state_n    = SCAN;
              dcnt_n     = {DW{1'b0}};
              key_held_n = 1'b0;
              row_n      = row_rot_s;
            end else begin
              state_n = RELEASE;
            end
          end else begin
            state_n = PRESSED;
          end
        end
        default: begin
          state_n = SCAN;
          row_n   = 4'b0001;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  assign row1       = row_r[0];
  assign row2       = row_r[1];
  assign row3       = row_r[2];
  assign row4       = row_r[3];
  assign key_code   = key_code_r;
  assign key_valid  = key_valid_r;
  assign key_held   = key_held_r;
  assign scan_state = state_r;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Bench for keypad_scan_controller: a rule-level keypad model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_keypad_scan_controller;

  localparam int SCAN_DIV = 4;
  localparam int DS       = 2;

  logic       clk = 1'b0;
  logic       initialize, col1, col2, col3, scan_en;
  logic       row1, row2, row3, row4, key_valid, key_held;
  logic [3:0] key_code;
  logic [1:0] scan_state;
  logic [3:0] rowv;

  keypad_scan_controller #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .initialize(initialize), .col1(col1), .col2(col2), .col3(col3),
    .scan_en(scan_en), .row1(row1), .row2(row2), .row3(row3), .row4(row4),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .scan_state(scan_state)
  );

  always #5 clk = ~clk;
  assign rowv = {row4, row3, row2, row1};

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Physical keypad: a held key closes its column only while its row is driven.
  int         key_row = 0;
  logic [2:0] key_mask = 3'b000;
  logic [2:0] force_mask = 3'b000;
  always @(negedge clk) begin
    logic [2:0] c;
    c = force_mask;
    if (key_row != 0 && rowv[key_row-1]) c = c | key_mask;
    {col3, col2, col1} = c;
  end

  always @(posedge clk) n_pulses += int'(key_valid);

  // Behavioural model: integer row index, press/release run lengths.
  logic [3:0] keytab [0:11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'hA, 4'h0, 4'hB};
  logic [2:0] m_s1, m_s2, m_pat;
  int         m_cnt, m_row, m_mode, m_run;
  logic [3:0] m_code;
  logic       m_valid, m_held;

  always @(posedge clk) begin
    if (initialize) begin
      m_cnt = 0; m_row = 0; m_mode = 0; m_run = 0; m_pat = 3'b000;
      m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
      m_s1 = 3'b000; m_s2 = 3'b000;
    end else begin
      m_valid = 1'b0;
      if (scan_en && m_cnt == SCAN_DIV - 1) begin
        case (m_mode)
          0: if ($countones(m_s2) == 1) begin m_pat = m_s2; m_run = 1; m_mode = 1; end
             else m_row = (m_row + 1) % 4;
          1: if (m_s2 == m_pat) begin
               m_run++;
               if (m_run >= DS) begin
                 m_mode = 2; m_valid = 1'b1; m_held = 1'b1;
                 m_code = keytab[m_row * 3 + (m_pat[0] ? 0 : (m_pat[1] ? 1 : 2))];
               end
             end else if ($countones(m_s2) == 1) begin m_pat = m_s2; m_run = 1; end
             else begin m_mode = 0; m_row = (m_row + 1) % 4; end
          2: if (m_s2 == 3'b000) begin m_run = 1; m_mode = 3; end
          default: if (m_s2 == 3'b000) begin
                     m_run++;
                     if (m_run >= DS) begin m_mode = 0; m_held = 1'b0; m_row = (m_row + 1) % 4; end
                   end else m_mode = 2;
        endcase
      end
      if (scan_en) m_cnt = (m_cnt + 1) % SCAN_DIV;
      m_s2 = m_s1;
      m_s1 = {col3, col2, col1};
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [3:0] one;
    one = 4'b0001;
    if (cmp_en)
      check("model", {rowv, key_code, key_valid, key_held, scan_state},
            {one << m_row, m_code, m_valid, m_held, 2'(m_mode)});
  end

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    int n;
    n = 0;
    while (scan_state != s && n < budget) begin @(negedge clk); n++; end
    if (scan_state != s) check({name, "_timeout"}, 32'(scan_state), 32'(s));
  endtask

  task automatic wait_unheld(input int budget, input string name);
    int n;
    n = 0;
    while (key_held && n < budget) begin @(negedge clk); n++; end
    if (key_held) check({name, "_timeout"}, 32'(key_held), 32'd0);
  endtask

  initial begin
    int p0, rchg, bad;
    logic [3:0] r0;
    initialize = 1'b1; scan_en = 1'b1;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_out", {rowv, key_code, key_valid, key_held, scan_state}, {4'b0001, 4'h0, 1'b0, 1'b0, 2'd0});
    initialize = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_rotate", rowv, 4'b0010);

    // Key '5' held 40 cycles.
    p0 = n_pulses; key_row = 2; key_mask = 3'b010;
    repeat (40) @(negedge clk);
    check("k5_pulses", n_pulses - p0, 1);
    check("k5_code", key_code, 4'd5);
    check("k5_held", key_held, 1'b1);
    check("k5_row", rowv, 4'b0010);
    check("k5_state", scan_state, 2'd2);
    key_row = 0;
    wait_unheld(40, "k5_release");
    check("k5_rel_row", rowv, 4'b0100);
    check("k5_rel_code", key_code, 4'd5);
    check("k5_rel_pulses", n_pulses - p0, 1);

    // Bouncing star key, then steady sharp.
    p0 = n_pulses; key_row = 4;
    for (int i = 0; i < 12; i++) begin
      key_mask = (i % 2 == 0) ? 3'b001 : 3'b000;
      repeat (SCAN_DIV) @(negedge clk);
    end
    check("bounce_pulses", n_pulses - p0, 0);
    p0 = n_pulses; key_mask = 3'b100;
    repeat (80) @(negedge clk);
    check("sharp_pulses", n_pulses - p0, 1);
    check("sharp_code", key_code, 4'hB);
    key_row = 0;
    wait_unheld(40, "sharp_release");
    repeat (8) @(negedge clk);

    // Two columns at once.
    p0 = n_pulses; force_mask = 3'b101; rchg = 0; bad = 0; r0 = rowv;
    repeat (40) begin
      @(negedge clk);
      if (scan_state != 2'd0) bad = 1;
      if (rowv != r0) rchg++;
      r0 = rowv;
    end
    check("multi_state", bad, 0);
    check("multi_pulses", n_pulses - p0, 0);
    check("multi_rotate", 32'(rchg >= 9), 1);
    force_mask = 3'b000;
    repeat (8) @(negedge clk);

    // Frozen scan with a key closed on the driven row.
    scan_en = 1'b0; p0 = n_pulses; r0 = rowv;
    for (int i = 0; i < 4; i++) if (r0[i]) key_row = i + 1;
    key_mask = 3'b010;
    repeat (20) @(negedge clk);
    check("freeze_row", rowv, r0);
    check("freeze_state", scan_state, 2'd0);
    check("freeze_pulses", n_pulses - p0, 0);
    key_row = 0;
    repeat (3) @(negedge clk);
    scan_en = 1'b1;
    repeat (12) @(negedge clk);

    // Reset while PRESSED.
    key_row = 1; key_mask = 3'b001;
    wait_state(2'd2, 60, "rst_pressed_wait");
    initialize = 1'b1; key_row = 0;
    @(negedge clk);
    check("rst_pressed", {rowv, key_code, key_valid, key_held, scan_state}, {4'b0001, 4'h0, 1'b0, 1'b0, 2'd0});
    initialize = 1'b0;
    repeat (12) @(negedge clk);

    // Reset on the accepting tick.
    key_row = 1; key_mask = 3'b001;
    wait_state(2'd1, 60, "rst_accept_wait");
    repeat (3) @(negedge clk);
    initialize = 1'b1; p0 = n_pulses;
    @(negedge clk);
    check("rst_accept", {rowv, key_code, key_valid, key_held, scan_state}, {4'b0001, 4'h0, 1'b0, 1'b0, 2'd0});
    initialize = 1'b0; key_row = 0;
    @(negedge clk);
    check("rst_accept_valid", key_valid, 1'b0);
    check("rst_accept_pulses", n_pulses - p0, 0);
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
